// File: rtl/spi_pwm_peripheral.sv
// SPI-programmable 16-channel output driver: five write-only control registers
// select per-channel static high or a shared ~3 kHz 8-bit-duty PWM waveform.
module spi_pwm_peripheral (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned FRAME_BITS   = 16;
  localparam int unsigned CNT_W        = 5;
  localparam int unsigned PRESCALE_MAX = 12;
  localparam int unsigned MAX_ADDR     = 4;

  logic [1:0]       r_sclk_s;
  logic [1:0]       r_copi_s;
  logic [1:0]       r_ncs_s;
  logic             r_sclk_prev;
  logic             r_ncs_prev;
  logic [1:0]       r_warm;
  logic             r_armed;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [15:0]      r_shift;
  logic [15:0]      r_en_out;
  logic [15:0]      r_en_pwm;
  logic [7:0]       r_duty;
  logic [3:0]       r_presc;
  logic [7:0]       r_pwm_cnt;
  logic [15:0]      r_out;

  logic w_sclk_rise;
  logic w_ncs_fall;
  logic w_ncs_rise;
  logic w_active;
  logic w_commit;
  logic w_pwm;
  logic w_unused;

  assign w_unused = &{1'b0, ena, uio_in, ui_in[7:3]};

  // Input synchronizers; nCS idles high so reset never looks like a frame start.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_sclk_s    <= 2'b00;
      r_copi_s    <= 2'b00;
      r_ncs_s     <= 2'b11;
      r_sclk_prev <= 1'b0;
      r_ncs_prev  <= 1'b1;
      r_warm      <= 2'b00;
      r_armed     <= 1'b0;
    end else begin
      r_sclk_s    <= {r_sclk_s[0], ui_in[0]};
      r_copi_s    <= {r_copi_s[0], ui_in[1]};
      r_ncs_s     <= {r_ncs_s[0], ui_in[2]};
      r_sclk_prev <= r_sclk_s[1];
      r_ncs_prev  <= r_ncs_s[1];
      r_warm      <= {r_warm[0], 1'b1};
      // Only a real idle-high nCS (not the reset value) arms frame tracking.
      r_armed     <= r_armed | (r_warm[1] & r_ncs_s[1]);
    end
  end

  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_prev;
  assign w_ncs_fall  = ~r_ncs_s[1] & r_ncs_prev & r_armed;
  assign w_ncs_rise  = r_ncs_s[1] & ~r_ncs_prev & r_armed;
  assign w_active    = ~r_ncs_s[1] & r_armed;
  assign w_commit    = w_ncs_rise
                     & (r_bit_cnt == CNT_W'(FRAME_BITS))
                     & r_shift[15]
                     & (r_shift[14:8] <= 7'(MAX_ADDR));

  // Shift register and saturating bit counter; the count sticks one past a full frame.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_ncs_fall) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (w_active && w_sclk_rise) begin
      if (r_bit_cnt < CNT_W'(FRAME_BITS)) begin
        r_shift <= {r_shift[14:0], r_copi_s[1]};
      end
      if (r_bit_cnt <= CNT_W'(FRAME_BITS)) begin
        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_en_out <= '0;
      r_en_pwm <= '0;
      r_duty   <= '0;
    end else if (w_commit) begin
      case (r_shift[10:8])
        3'd0:    r_en_out[7:0]  <= r_shift[7:0];
        3'd1:    r_en_out[15:8] <= r_shift[7:0];
        3'd2:    r_en_pwm[7:0]  <= r_shift[7:0];
        3'd3:    r_en_pwm[15:8] <= r_shift[7:0];
        3'd4:    r_duty         <= r_shift[7:0];
        default: ;
      endcase
    end
  end

  // Divide-by-13 prescaler feeding a free-running 8-bit PWM counter.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_presc   <= '0;
      r_pwm_cnt <= '0;
    end else if (r_presc == 4'(PRESCALE_MAX)) begin
      r_presc   <= '0;
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
    end else begin
      r_presc   <= r_presc + 4'd1;
    end
  end

  assign w_pwm = (r_duty == 8'hFF) | (r_pwm_cnt < r_duty);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_out <= '0;
    end else begin
      r_out <= r_en_out & (~r_en_pwm | {16{w_pwm}});
    end
  end

  assign uo_out  = r_out[7:0];
  assign uio_out = r_out[15:8];
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_spi_pwm_peripheral.sv
// Directed bench for spi_pwm_peripheral: SPI register writes, discarded frames,
// and PWM period/duty measurement against hand-computed cycle counts.
module tb_spi_pwm_peripheral;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic r_sclk;
  logic r_copi;
  logic r_ncs;

  int n_checks;
  int n_passed;

  assign ui_in  = {5'b0, r_ncs, r_copi, r_sclk};
  assign ena    = 1'b1;
  assign uio_in = 8'h00;

  spi_pwm_peripheral dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_passed++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Shifts out the low n bits of 'bits', MSB first, then leaves 4 clk for the commit.
  task automatic spi_xfer(input logic [16:0] bits, input int n);
    r_ncs = 1'b0;
    wait_clk(3);
    for (int i = n - 1; i >= 0; i--) begin
      r_copi = bits[i];
      wait_clk(3);
      r_sclk = 1'b1;
      wait_clk(3);
      r_sclk = 1'b0;
    end
    wait_clk(3);
    r_ncs = 1'b1;
    wait_clk(4);
  endtask

  task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
    spi_xfer({1'b0, 1'b1, addr, data}, 16);
  endtask

  function automatic logic pwm_bit(input bit sel);
    return sel ? uio_out[0] : uo_out[0];
  endfunction

  // Aligns to a rising edge, then counts high and low samples of one full period.
  task automatic measure(input bit sel, output int hi, output int lo);
    int guard;
    guard = 0;
    hi = 0;
    lo = 0;
    @(negedge clk);
    while (pwm_bit(sel) !== 1'b0 && guard < 10000) begin @(negedge clk); guard++; end
    while (pwm_bit(sel) !== 1'b1 && guard < 10000) begin @(negedge clk); guard++; end
    check("pwm_rise_seen", 32'(guard < 10000), 32'd1);
    if (guard < 10000) begin
      while (pwm_bit(sel) === 1'b1 && hi < 10000) begin @(negedge clk); hi++; end
      while (pwm_bit(sel) === 1'b0 && lo < 10000) begin @(negedge clk); lo++; end
    end
  endtask

  int hi;
  int lo;
  int ones;
  int zeros;
  int nonzero;

  initial begin
    n_checks = 0;
    n_passed = 0;
    r_sclk   = 1'b0;
    r_copi   = 1'b0;
    r_ncs    = 1'b1;
    rst_n    = 1'b1;

    wait_clk(5);
    @(negedge clk);
    check("reset_uo", 32'(uo_out), 32'h00);
    check("reset_uio", 32'(uio_out), 32'h00);
    check("reset_oe", 32'(uio_oe), 32'hFF);
    rst_n = 1'b0;
    wait_clk(4);
    @(negedge clk);
    check("post_reset_uo", 32'(uo_out), 32'h00);
    check("post_reset_uio", 32'(uio_out), 32'h00);

    spi_write(7'h00, 8'hF0);
    @(negedge clk);
    check("en_out_lo", 32'(uo_out), 32'hF0);
    spi_write(7'h01, 8'hCC);
    @(negedge clk);
    check("en_out_hi", 32'(uio_out), 32'hCC);

    spi_xfer({1'b0, 1'b0, 7'h00, 8'hFF}, 16);
    @(negedge clk);
    check("read_ignored", 32'(uo_out), 32'hF0);
    spi_xfer({1'b0, 1'b1, 7'h30, 8'hFF}, 16);
    @(negedge clk);
    check("bad_addr_uo", 32'(uo_out), 32'hF0);
    check("bad_addr_uio", 32'(uio_out), 32'hCC);
    spi_xfer({2'b0, 15'h000F}, 15);
    @(negedge clk);
    check("short_frame", 32'(uo_out), 32'hF0);
    spi_xfer({1'b1, 7'h00, 8'h0F, 1'b0}, 17);
    @(negedge clk);
    check("long_frame", 32'(uo_out), 32'hF0);

    spi_write(7'h00, 8'h01);
    spi_write(7'h02, 8'h01);
    spi_write(7'h04, 8'h80);
    @(negedge clk);
    check("pwm_others_low", 32'(uo_out & 8'hFE), 32'h00);
    measure(1'b0, hi, lo);
    check("pwm50_high", 32'(hi), 32'd1664);
    check("pwm50_period", 32'((hi + lo >= 3327) && (hi + lo <= 3329)), 32'd1);

    spi_write(7'h04, 8'h00);
    wait_clk(2);
    ones = 0;
    for (int i = 0; i < 7000; i++) begin
      @(negedge clk);
      if (uo_out[0] !== 1'b0) ones++;
    end
    check("duty00_low", 32'(ones), 32'd0);

    spi_write(7'h04, 8'hFF);
    wait_clk(2);
    zeros = 0;
    for (int i = 0; i < 7000; i++) begin
      @(negedge clk);
      if (uo_out[0] !== 1'b1) zeros++;
    end
    check("dutyFF_high", 32'(zeros), 32'd0);

    spi_write(7'h03, 8'hFF);
    spi_write(7'h04, 8'h40);
    spi_write(7'h01, 8'h00);
    nonzero = 0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (uio_out !== 8'h00) nonzero++;
    end
    check("masked_uio", 32'(nonzero), 32'd0);

    spi_write(7'h01, 8'h01);
    measure(1'b1, hi, lo);
    check("pwm25_high", 32'(hi), 32'd832);
    check("pwm25_low", 32'(lo), 32'd2496);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_pwm_peripheral.md
# spi_pwm_peripheral

This block is the top-level user module of the onboarding tile: an SPI-programmable 16-channel output driver. An external SPI controller writes five 8-bit control registers. The registers enable each of 16 outputs and select, per output, a static high level or a shared PWM waveform of about 3 kHz with an 8-bit duty cycle. It occupies the standard tile wrapper and drives all dedicated outputs and all bidirectional pins as outputs.

## Interface
Parameters: none.
- clk  in  1  system clock, 10 MHz nominal; all logic is single-domain on its rising edge.
- rst_n  in  1  asynchronous, active-high reset. The port keeps the codebase name, but the block is in reset while rst_n = 1.
- ena  in  1  tile select; ignored.
- ui_in  in  8  [0] SCLK, [1] COPI, [2] nCS (active-low); [7:3] unused.
- uio_in  in  8  unused.
- uo_out  out  8  channel outputs 7..0.
- uio_out  out  8  channel outputs 15..8.
- uio_oe  out  8  constant 8'hFF.

## Operation
- SPI inputs (SCLK, COPI, nCS):
  - Each passes through a 2-FF synchronizer into clk.
  - SCLK rising edges are detected from the synchronized value.
- SPI protocol:
  - Mode 0; COPI is sampled on the SCLK rising edge; MSB first.
  - Frame is 16 bits: bit15 R/W (1 = write), bits14:8 address, bits7:0 data.
  - nCS falling edge clears the bit counter and shift register.
  - Bits are counted only while nCS is low.
  - Commit happens on the nCS rising edge only if all of the following hold: exactly 16 bits received, R/W = 1, address ≤ 0x04.
  - Any other frame is discarded with no register change. This covers wrong bit count, reads, and addresses 0x05–0x7F.
  - There is no read-back.
- Registers (all reset to 0x00):
  - 0x00 en_out[7:0]
  - 0x01 en_out[15:8]
  - 0x02 en_pwm[7:0]
  - 0x03 en_pwm[15:8]
  - 0x04 duty
- PWM generator:
  - Prescaler counts 0..12 and wraps, giving one tick every 13 clk.
  - The tick advances an 8-bit counter 0..255 that wraps.
  - Period = 3328 clk ≈ 3.005 kHz at 10 MHz.
  - pwm = 1 when duty == 0xFF; otherwise pwm = 1 when counter < duty.
  - duty 0x00 gives constant low.
  - High time = duty×13 clk per period, except duty 0xFF.
- Output for channel i:
  - out[i] = en_out[i] ? (en_pwm[i] ? pwm : 1) : 0.
  - en_pwm has no effect when en_out = 0.
  - uo_out = out[7:0]; uio_out = out[15:8].

## Timing
- During reset:
  - All registers are 0x00, the prescaler and PWM counter are 0, and the synchronizers are cleared with nCS forced high (idle).
  - uo_out = 0x00, uio_out = 0x00, uio_oe = 0xFF.
- Write latency: the register and its outputs update within 4 clk of the nCS rising edge at the pin (2-FF sync, edge detect, register).
- SCLK constraint: SCLK frequency ≤ clk/5. The high and low phases must each be ≥ 2 clk.
- nCS setup/hold: nCS must fall ≥ 2 clk before the first SCLK rise and rise ≥ 2 clk after the last one.
- Bit count overflow: more than 16 SCLK rises in one frame makes the frame invalid (discarded). Shifting saturates, so no wrap to a valid count.
- Reset mid-frame: the frame is abandoned and registers return to 0. A frame already in progress when reset releases is ignored until the next nCS falling edge.
- Duty update: a new duty value applies to the compare immediately. The counter is never reset by writes, so the current period may be truncated or extended once.
- Back-to-back frames are allowed with nCS high for ≥ 2 clk between them.

## Test plan
- Reset: hold rst_n = 1 for 5 clk, then release → uo_out = 0x00, uio_out = 0x00, uio_oe = 0xFF.
- Static enable:
  - Write 0x00 ← 0xF0 → uo_out = 0xF0 within 4 clk of nCS high.
  - Write 0x01 ← 0xCC → uio_out = 0xCC.
- Invalid frames are ignored:
  - Read frame (bit15 = 0) to 0x00 with data 0xFF → no change.
  - Write to 0x30 → no change.
  - Frame of 15 bits → no change.
- PWM duty 50%: write 0x00 ← 0x01, 0x02 ← 0x01, 0x04 ← 0x80 → uo_out[0] period 3328 clk (±1 clk), high 1664 clk.
- PWM extremes, with the same enables:
  - duty 0x00 → uo_out[0] stays 0 for ≥ 7000 clk.
  - duty 0xFF → uo_out[0] stays 1 for ≥ 7000 clk.
- PWM masked by enable: write 0x03 ← 0xFF, 0x04 ← 0x40, 0x01 ← 0x00 → uio_out = 0x00 constantly. Then write 0x01 ← 0x01 → uio_out[0] toggles with 25% duty (high 832 clk per 3328).
